// File: rtl/stream_fifo_buffer.sv
// stream_fifo_buffer: DEPTH-entry first-word-fall-through stream buffer with level, almost-full and flush.
// Handshake outputs decode only the level register, so out_ready never reaches in_ready combinationally.
module stream_fifo_buffer #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 4,
    parameter int ALMOST_FULL = 3
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic                         flush,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         almost_full
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  wr, rd;

    // Flush wins over any same-edge handshake; pointers wrap by natural overflow.
    always_comb begin
        wr       = in_valid & in_ready;
        rd       = out_valid & out_ready;
        wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(wr);
        rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(rd);
        level_d  = flush ? '0 : level_q + LW'(wr) - LW'(rd);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (wr && !flush)
            mem_q[wr_ptr_q] <= in_data;
    end

    assign in_ready    = level_q != LW'(DEPTH);
    assign out_valid   = level_q != '0;
    assign almost_full = level_q >= LW'(ALMOST_FULL);
    assign level       = level_q;
    assign out_data    = mem_q[rd_ptr_q];
endmodule

// File: tb/tb_stream_fifo_buffer.sv
// tb_stream_fifo_buffer: vector table, corner sequences and random traffic against a queue model.
module tb_stream_fifo_buffer;
    localparam int DEPTH = 4;
    localparam int AF    = 3;

    logic        aclk = 0, areset = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic [31:0] in_data = 0;
    logic        in_ready, out_valid, almost_full;
    logic [31:0] out_data;
    logic [2:0]  level;

    int errors = 0, checks = 0;
    logic [31:0] q[$];
    logic mdl_wr;

    stream_fifo_buffer #(.DATA_WIDTH(32), .DEPTH(DEPTH), .ALMOST_FULL(AF)) dut (
        .aclk(aclk), .areset(areset), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .almost_full(almost_full)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic f, iv; logic [31:0] d; logic ordy;
        int lvl; logic ov; logic [31:0] od; logic chk_od; logic ir, af;
    } vec_t;
    vec_t v[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, advance the reference queue at the edge, then settle past it.
    task automatic apply(input logic f, input logic iv, input logic [31:0] d, input logic ordy);
        logic rd;
        flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        @(posedge aclk);
        mdl_wr = iv && q.size() < DEPTH;
        rd = ordy && q.size() > 0;
        if (f) q.delete();
        else begin
            if (rd) void'(q.pop_front());
            if (mdl_wr) q.push_back(d);
        end
        #1;
    endtask

    task automatic model_check(input string tag);
        chk({tag, ".level"}, 32'(level), 32'(q.size()));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < DEPTH));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(q.size() >= AF));
        if (q.size() > 0) chk({tag, ".out_data"}, out_data, q[0]);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int accepted;
        v[0]  = '{0,1,32'h11,0, 1,1,32'h11,1,1,0};
        v[1]  = '{0,1,32'h22,0, 2,1,32'h11,1,1,0};
        v[2]  = '{0,1,32'h33,0, 3,1,32'h11,1,1,1};
        v[3]  = '{0,0,32'h00,1, 2,1,32'h22,1,1,0};
        v[4]  = '{0,0,32'h00,1, 1,1,32'h33,1,1,0};
        v[5]  = '{0,0,32'h00,1, 0,0,32'h00,0,1,0};
        v[6]  = '{0,1,32'hA0,0, 1,1,32'hA0,1,1,0};
        v[7]  = '{0,1,32'hA1,0, 2,1,32'hA0,1,1,0};
        v[8]  = '{0,1,32'hA2,0, 3,1,32'hA0,1,1,1};
        v[9]  = '{0,1,32'hA3,0, 4,1,32'hA0,1,0,1};
        v[10] = '{0,1,32'hA4,1, 3,1,32'hA1,1,1,1};
        v[11] = '{0,1,32'hA4,0, 4,1,32'hA1,1,0,1};
        v[12] = '{0,0,32'h00,1, 3,1,32'hA2,1,1,1};
        v[13] = '{1,1,32'hEE,1, 0,0,32'h00,0,1,0};
        v[14] = '{0,1,32'h05,0, 1,1,32'h05,1,1,0};
        v[15] = '{0,0,32'h00,1, 0,0,32'h00,0,1,0};

        #2;
        chk("rst.level", 32'(level), 0);
        chk("rst.out_valid", 32'(out_valid), 0);
        chk("rst.in_ready", 32'(in_ready), 1);
        chk("rst.almost_full", 32'(almost_full), 0);
        #10 areset = 0;

        for (int i = 0; i < 16; i++) begin
            apply(v[i].f, v[i].iv, v[i].d, v[i].ordy);
            chk($sformatf("vec%0d.level", i), 32'(level), 32'(v[i].lvl));
            chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(v[i].ov));
            chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(v[i].ir));
            chk($sformatf("vec%0d.almost_full", i), 32'(almost_full), 32'(v[i].af));
            if (v[i].chk_od) chk($sformatf("vec%0d.out_data", i), out_data, v[i].od);
        end

        for (int i = 0; i < 100; i++) begin
            apply(0, 1, 32'(i), 1);
            chk("thru.out_data", out_data, 32'(i));
            chk("thru.level", 32'(level), 1);
            model_check("thru");
        end
        apply(0, 0, 0, 1);
        model_check("thru_drain");

        apply(0, 1, 32'h61, 0);
        apply(0, 1, 32'h62, 0);
        model_check("pre_reset");
        #3 areset = 1;
        #1;
        chk("arst.level", 32'(level), 0);
        chk("arst.out_valid", 32'(out_valid), 0);
        chk("arst.in_ready", 32'(in_ready), 1);
        chk("arst.almost_full", 32'(almost_full), 0);
        q.delete();
        #3 areset = 0;
        apply(0, 1, 32'h5A, 0);
        chk("arst.first_word", out_data, 32'h5A);
        model_check("post_reset");
        apply(0, 0, 0, 1);

        accepted = 0;
        for (int c = 0; c < 20000 && accepted < 1000; c++) begin
            apply(0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
            if (mdl_wr) accepted++;
            model_check("rand");
        end
        chk("rand.accepted", 32'(accepted), 1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stream_fifo_buffer.md
Name: stream_fifo_buffer

Overview:
- Parametrised successor to the single-register AXI4-Stream output stage: a DEPTH-entry first-word-fall-through buffer.
- All outputs are register-driven, so there is no combinational path from out_ready to in_ready, and upstream timing is decoupled from downstream timing.
- Adds an occupancy level, a programmable almost-full flag and a synchronous flush.
- Sits between DSP/ADC stream producers and DMA/packetiser consumers.

Parameters:
DATA_WIDTH, 32, width of data bus in bits
DEPTH, 4, number of storage entries; power of two, >= 2
ALMOST_FULL, 3, level at or above which almost_full asserts; 1..DEPTH

Ports:
aclk  input  1  clock, all logic on rising edge
areset  input  1  asynchronous, active-high reset
flush  input  1  synchronous discard of all stored entries
in_data  input  DATA_WIDTH  upstream data
in_valid  input  1  upstream valid
in_ready  output  1  buffer can accept; high when level < DEPTH
out_data  output  DATA_WIDTH  head-of-buffer data
out_valid  output  1  head entry present; high when level > 0
out_ready  input  1  downstream ready
level  output  clog2(DEPTH+1)  number of stored entries, 0..DEPTH
almost_full  output  1  high when level >= ALMOST_FULL

Behaviour:
- Reset (areset high, asynchronous):
  - write pointer, read pointer and level go to 0 immediately, without waiting for a clock edge.
  - Outputs while in reset: out_valid=0, in_ready=1, level=0, almost_full=0. out_data is don't-care.
  - Storage array is not reset.
- Handshakes:
  - Write occurs at a rising edge when in_valid & in_ready.
  - Read occurs at a rising edge when out_valid & out_ready.
  - in_ready, out_valid, level and almost_full are decoded from registered level only. None depends combinationally on in_valid or out_ready.
- Latency:
  - Word written into an empty buffer at edge N shows out_valid=1 and out_data equal to that word in the cycle after edge N.
  - Minimum latency is 1 cycle.
- Ordering: strict FIFO. out_data always equals mem[rd_ptr] and stays stable while out_valid=1 and out_ready=0.
- Pointers:
  - Width log2(DEPTH); wrap from DEPTH-1 to 0 by natural overflow.
  - Level is a separate counter of width clog2(DEPTH+1).
- Level update per edge:
  - write only: +1
  - read only: -1
  - both: unchanged, and both pointers advance
  - neither: unchanged
- Full (level=DEPTH):
  - in_ready=0 for the whole cycle, even if out_ready=1. The slot freed by a read becomes visible as in_ready=1 the next cycle.
  - Sustained full-rate throughput is guaranteed whenever level < DEPTH.
- Empty (level=0): out_valid=0. A write and a read cannot both occur in the same cycle, so there is no bypass path.
- Simultaneous read and write at level 1..DEPTH-1: both complete, level unchanged.
- Flush (sampled at edge, higher priority than read or write):
  - Pointers and level are cleared at that edge.
  - Any write or read handshake in the same cycle is discarded: the input word is dropped and the read is not counted.
  - Upstream sees in_ready as computed before the edge; the accepted word is dropped.
- almost_full = (level >= ALMOST_FULL), decoded from the level register.
- Reset asserted mid-operation discards all content. After reset deassertion, first write is legal at the first edge.
- Data does not pass through reset or flush.

Test Plan:
- Basic ordering: DEPTH=4; write 0x11, 0x22, 0x33 with out_ready=0 -> level=3, almost_full=1, out_data=0x11; then out_ready=1 -> outputs 0x11, 0x22, 0x33 in consecutive cycles, level returns to 0, out_valid=0.
- Full and backpressure: write 0xA0..0xA3 with out_ready=0 -> in_ready=0 after 4th write, level=4; hold in_valid with 0xA4 and pulse out_ready for 1 cycle -> 0xA0 read, in_ready=1 next cycle, 0xA4 accepted the cycle after, order preserved.
- Full throughput: in_valid=1 and out_ready=1 continuous, data counter 0..99 -> 100 words out in order, one per cycle after 1-cycle latency, level steady at 1.
- Random stall: random in_valid and out_ready (50% each), 1000 words -> scoreboard matches exactly; level never exceeds 4; in_ready=0 exactly when level=4.
- Flush with concurrent handshake: level=3, flush=1 with in_valid=1, in_ready=1, out_ready=1 in the same cycle -> next cycle level=0, out_valid=0; the in-flight word never appears at the output.
- Async reset mid-stream: assert areset between clock edges at level=2 -> out_valid=0, level=0, in_ready=1 before the next edge; after release, write 0x5A -> out_data=0x5A next cycle.
